hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the rvga core. It generates per-stage stall and flush vectors for an arbitrary stage count.
- It tracks outstanding requests on multiple memory ports with per-port counters. It detects load-use hazards with an internal load-destination shadow pipeline and inserts bubbles.
- Redirect flushes are resolved with oldest-wins priority.
- Sits beside the datapath. All pipeline registers take stall/flush from this block.

Parameters:
- STAGES, 6: pipeline stage count. Stage 0 is ifetch (youngest); stage STAGES-1 is oldest.
- DECODE_IDX, 1: stage index where source registers are read. Load-use interlock stalls stages 0..DECODE_IDX.
- PORTS, 2: number of memory ports (port 0 imem, port 1 dmem by convention).
- MAX_OUTST, 2: maximum outstanding requests per port. Counter width is clog2(MAX_OUTST+1).
- LD_LAT, 2: number of stages after decode in which a load result is not yet forwardable.
- REG_W, 5: register address width.
- TIMEOUT_W, 8: watchdog counter width (optional feature only).

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- mem_req_v_i  in  PORTS  request accepted on port p this cycle
- mem_resp_v_i  in  PORTS  response returned on port p this cycle
- mem_need_v_i  in  PORTS  consuming stage requires the port-p response this cycle
- br_v_i  in  STAGES  redirect raised by stage k
- ld_issue_v_i  in  1  instruction in DECODE_IDX is a load
- ld_rd_i  in  REG_W  load destination register
- rs_v_i  in  2  rs1/rs2 used by the decode instruction
- rs1_i  in  REG_W  source register 1
- rs2_i  in  REG_W  source register 2
- stall_v_o  out  STAGES  hold stage k
- flush_v_o  out  STAGES  invalidate stage k
- bubble_v_o  out  1  inject NOP into stage DECODE_IDX+1
- mem_wait_v_o  out  1  global memory stall
- mem_full_o  out  PORTS  port p at MAX_OUTST
- timeout_o  out  1  watchdog fired (sticky)

Behaviour:
- Reset is synchronous and active-high on reset_i, sampled at the clk_i rising edge. While reset_i is asserted:
  - all outstanding counters, shadow entries and the watchdog counter clear to 0;
  - all outputs are 0 (combinational outputs are 0 because state is 0 and reset_i gates them).
- Reset mid-operation discards all tracked requests; late responses are then ignored.
- Outstanding counter per port:
  - +1 on req only, -1 on resp only, unchanged on simultaneous req+resp.
  - A req at MAX_OUTST is dropped (saturates). A resp at 0 is ignored; the counter never wraps.
  - mem_full_o[p] = (cnt[p]==MAX_OUTST).
- mem_wait_v_o = OR over p of (mem_need_v_i[p] & cnt[p]!=0 & ~mem_resp_v_i[p]). This is combinational with zero latency; a same-cycle response releases the stall.
- When mem_wait_v_o=1:
  - stall_v_o is all ones;
  - flush_v_o=0 and bubble_v_o=0;
  - the redirect is held by its stage and acted on the first non-waiting cycle.
- Redirect: k* is the highest k with br_v_i[k]=1 (oldest wins). flush_v_o[j]=1 for all j<k*. Stage k* itself is not flushed.
- Load-use interlock:
  - The shadow pipeline has LD_LAT entries {v, rd}. Entry i corresponds to stage DECODE_IDX+1+i.
  - hit = any entry v & rd!=0 & ((rs_v_i[0] & rd==rs1_i) | (rs_v_i[1] & rd==rs2_i)). x0 never hits.
  - On hit (and no mem wait): stall_v_o[0..DECODE_IDX]=1 and bubble_v_o=1; older stages advance.
- Shadow pipeline update:
  - If not mem-waiting, entries shift by one. Entry 0 loads {ld_issue_v_i & ~hit & ~flush_v_o[DECODE_IDX], ld_rd_i}.
  - Entries whose stage is flushed are cleared in the same update.
  - During a mem wait the shadow pipeline holds.
- Priority when flush and hit coincide: flush of DECODE_IDX wins. bubble_v_o=0, stall_v_o[0..DECODE_IDX]=0.

Optional Feature:
- Macro: RVGA_HAZARD_WATCHDOG_EN.
- Enabled:
  - a TIMEOUT_W-bit counter increments each cycle mem_wait_v_o=1 and clears on any non-waiting cycle;
  - at all ones, timeout_o sets and stays set until reset_i.
  - Stall behaviour is unchanged.
- Disabled: no counter; timeout_o tied 0.

Test Plan:
- Reset check: assert reset_i with br_v_i=all ones and mem_need_v_i=all ones; release reset -> every output 0 for the first cycle; counters and shadow entries 0.
- Memory wait on dmem:
  - req on port 1, then mem_need_v_i[1]=1 for 3 cycles with no resp -> mem_wait_v_o=1 and stall_v_o=6'b111111 for 3 cycles;
  - resp in cycle 4 -> mem_wait_v_o=0 that same cycle; cnt returns to 0.
- Saturation and underflow (MAX_OUTST=2): 3 reqs with no resp -> mem_full_o[0]=1, count stays 2; then 3 resps -> count 0, no wrap.
- Load-use, LD_LAT=2:
  - load with ld_rd_i=5, next decode with rs1_i=5 -> 2 cycles of bubble_v_o=1 and stall_v_o=6'b000011, then release;
  - rd=0 with rs1_i=0 -> no stall.
- Oldest-wins redirect: br_v_i[2] and br_v_i[4] in the same cycle -> flush_v_o=6'b001111.
- Held redirect: the same br_v_i pattern during a mem wait -> flush_v_o=0 until the wait clears, then 6'b001111.
- Flush/hit collision: hit coincides with br_v_i[3] -> bubble_v_o=0, flush_v_o=6'b000111. With RVGA_HAZARD_WATCHDOG_EN and TIMEOUT_W=4, a 15-cycle wait sets timeout_o and it stays set.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: outstanding-request tracking, load-use interlock,
// oldest-wins redirect flush. Optional watchdog under RVGA_HAZARD_WATCHDOG_EN.
module hazard_ctrl #(
  parameter int STAGES     = 6,
  parameter int DECODE_IDX = 1,
  parameter int PORTS      = 2,
  parameter int MAX_OUTST  = 2,
  parameter int LD_LAT     = 2,
  parameter int REG_W      = 5,
  parameter int TIMEOUT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [PORTS-1:0]  mem_req_v_i,
  input  logic [PORTS-1:0]  mem_resp_v_i,
  input  logic [PORTS-1:0]  mem_need_v_i,
  input  logic [STAGES-1:0] br_v_i,
  input  logic              ld_issue_v_i,
  input  logic [REG_W-1:0]  ld_rd_i,
  input  logic [1:0]        rs_v_i,
  input  logic [REG_W-1:0]  rs1_i,
  input  logic [REG_W-1:0]  rs2_i,
  output logic [STAGES-1:0] stall_v_o,
  output logic [STAGES-1:0] flush_v_o,
  output logic              bubble_v_o,
  output logic              mem_wait_v_o,
  output logic [PORTS-1:0]  mem_full_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  r_cnt [PORTS];
  logic [LD_LAT-1:0] r_sh_v;
  logic [REG_W-1:0]  r_sh_rd [LD_LAT];

  logic [PORTS-1:0]  w_wait_p;
  logic [PORTS-1:0]  w_full;
  logic              w_mem_wait;
  logic [STAGES-1:0] w_flush_raw;
  logic [STAGES-1:0] w_flush;
  logic              w_hit;
  logic              w_bubble;
  logic [STAGES-1:0] w_stall;

  // Outstanding counters saturate at MAX_OUTST and never drop below zero.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < PORTS; p++) begin
      if (reset_i) begin
        r_cnt[p] <= '0;
      end else if (mem_req_v_i[p] && !mem_resp_v_i[p] && (r_cnt[p] != CNT_MAX)) begin
        r_cnt[p] <= r_cnt[p] + CNT_ONE;
      end else if (mem_resp_v_i[p] && !mem_req_v_i[p] && (r_cnt[p] != '0)) begin
        r_cnt[p] <= r_cnt[p] - CNT_ONE;
      end
    end
  end

  always_comb begin
    w_wait_p = '0;
    w_full   = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_wait_p[p] = mem_need_v_i[p] & (r_cnt[p] != '0) & ~mem_resp_v_i[p];
      w_full[p]   = (r_cnt[p] == CNT_MAX);
    end
  end

  assign w_mem_wait = ~reset_i & (|w_wait_p);

  // Stage j is flushed when any older stage raises a redirect.
  always_comb begin
    logic v_older;
    v_older     = 1'b0;
    w_flush_raw = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_flush_raw[k] = v_older;
      v_older        = v_older | br_v_i[k];
    end
  end

  assign w_flush = (reset_i || w_mem_wait) ? '0 : w_flush_raw;

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < LD_LAT; i++) begin
      if (r_sh_v[i] && (r_sh_rd[i] != '0) &&
          ((rs_v_i[0] && (r_sh_rd[i] == rs1_i)) ||
           (rs_v_i[1] && (r_sh_rd[i] == rs2_i)))) begin
        w_hit = 1'b1;
      end
    end
  end

  // A flush of the decode stage removes the consumer, so no interlock is needed.
  assign w_bubble = ~reset_i & ~w_mem_wait & w_hit & ~w_flush[DECODE_IDX];

  always_comb begin
    w_stall = '0;
    if (w_mem_wait) begin
      w_stall = '1;
    end else if (w_bubble) begin
      for (int k = 0; k <= DECODE_IDX; k++) begin
        w_stall[k] = 1'b1;
      end
    end
  end

  // Shadow entry i mirrors stage DECODE_IDX+1+i; an entry leaving a flushed stage dies.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sh_v <= '0;
      for (int i = 0; i < LD_LAT; i++) begin
        r_sh_rd[i] <= '0;
      end
    end else if (!w_mem_wait) begin
      r_sh_v[0]  <= ld_issue_v_i & ~w_hit & ~w_flush[DECODE_IDX];
      r_sh_rd[0] <= ld_rd_i;
      for (int i = 1; i < LD_LAT; i++) begin
        r_sh_v[i]  <= r_sh_v[i-1] & ~w_flush[DECODE_IDX+i];
        r_sh_rd[i] <= r_sh_rd[i-1];
      end
    end
  end

`ifdef RVGA_HAZARD_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_timeout;
  logic [TIMEOUT_W-1:0] w_wd_next;

  assign w_wd_next = (r_wd == '1) ? r_wd : r_wd + TIMEOUT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_mem_wait) begin
      r_wd <= w_wd_next;
      if (w_wd_next == '1) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wd <= '0;
    end
  end

  assign timeout_o = ~reset_i & r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  assign stall_v_o    = w_stall;
  assign flush_v_o    = w_flush;
  assign bubble_v_o   = w_bubble;
  assign mem_wait_v_o = w_mem_wait;
  assign mem_full_o   = reset_i ? '0 : w_full;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, all checked
// against a stage-position model of in-flight loads and per-port request counts.
module tb_hazard_ctrl;
  localparam int S  = 6;
  localparam int P  = 2;
  localparam int D  = 1;
  localparam int MO = 2;
  localparam int LL = 2;
  localparam int RW = 5;
  localparam int TW = 8;
`ifdef RVGA_HAZARD_WATCHDOG_EN
  localparam int WD_N   = (1 << TW) - 1;
  localparam int EXP_TO = 1;
`else
  localparam int WD_N   = 20;
  localparam int EXP_TO = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic [P-1:0]  mem_req_v_i, mem_resp_v_i, mem_need_v_i;
  logic [S-1:0]  br_v_i;
  logic          ld_issue_v_i;
  logic [RW-1:0] ld_rd_i;
  logic [1:0]    rs_v_i;
  logic [RW-1:0] rs1_i, rs2_i;
  logic [S-1:0]  stall_v_o, flush_v_o;
  logic          bubble_v_o, mem_wait_v_o, timeout_o;
  logic [P-1:0]  mem_full_o;

  hazard_ctrl #(
    .STAGES(S), .DECODE_IDX(D), .PORTS(P), .MAX_OUTST(MO),
    .LD_LAT(LL), .REG_W(RW), .TIMEOUT_W(TW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .mem_req_v_i(mem_req_v_i), .mem_resp_v_i(mem_resp_v_i), .mem_need_v_i(mem_need_v_i),
    .br_v_i(br_v_i), .ld_issue_v_i(ld_issue_v_i), .ld_rd_i(ld_rd_i),
    .rs_v_i(rs_v_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .stall_v_o(stall_v_o), .flush_v_o(flush_v_o), .bubble_v_o(bubble_v_o),
    .mem_wait_v_o(mem_wait_v_o), .mem_full_o(mem_full_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  // Model: each in-flight load remembers which stage it occupies.
  typedef struct { int stage; logic [RW-1:0] rd; } ld_t;
  ld_t m_lds[$];
  int  m_cnt[P];
  int  m_wd;
  bit  m_to;
  bit  e_wait, e_hit;
  int  e_k;
  int  n_chk = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    reset_i = 1'b0; mem_req_v_i = '0; mem_resp_v_i = '0; mem_need_v_i = '0;
    br_v_i = '0; ld_issue_v_i = 1'b0; ld_rd_i = '0; rs_v_i = '0; rs1_i = '0; rs2_i = '0;
  endtask

  task automatic chk_model();
    logic [31:0] e_stall, e_flush, e_full;
    bit          e_bub;
    #1;
    e_wait = 0; e_hit = 0; e_k = -1;
    e_stall = 0; e_flush = 0; e_full = 0; e_bub = 0;
    if (!reset_i) begin
      for (int p = 0; p < P; p++) begin
        if (mem_need_v_i[p] && m_cnt[p] > 0 && !mem_resp_v_i[p]) e_wait = 1;
        if (m_cnt[p] == MO) e_full[p] = 1'b1;
      end
      for (int k = 0; k < S; k++) if (br_v_i[k]) e_k = k;
      foreach (m_lds[i]) begin
        if (m_lds[i].rd != 0 && ((rs_v_i[0] && m_lds[i].rd == rs1_i) ||
                                 (rs_v_i[1] && m_lds[i].rd == rs2_i))) e_hit = 1;
      end
      if (e_wait) begin
        e_stall = (32'd1 << S) - 1;
      end else begin
        e_flush = (e_k > 0) ? ((32'd1 << e_k) - 1) : 0;
        e_bub   = e_hit && !(e_k > D);
        e_stall = e_bub ? ((32'd1 << (D + 1)) - 1) : 0;
      end
    end
    chk("stall", stall_v_o, e_stall);
    chk("flush", flush_v_o, e_flush);
    chk("bubble", bubble_v_o, e_bub);
    chk("mem_wait", mem_wait_v_o, e_wait);
    chk("mem_full", mem_full_o, e_full);
    chk("timeout", timeout_o, (!reset_i && m_to) ? 1 : 0);
  endtask

  task automatic adv();
    ld_t nq[$];
    @(posedge clk);
    if (reset_i) begin
      for (int p = 0; p < P; p++) m_cnt[p] = 0;
      m_lds.delete();
      m_wd = 0; m_to = 0;
    end else begin
      for (int p = 0; p < P; p++) begin
        if (mem_req_v_i[p] && !mem_resp_v_i[p] && m_cnt[p] < MO) m_cnt[p]++;
        else if (mem_resp_v_i[p] && !mem_req_v_i[p] && m_cnt[p] > 0) m_cnt[p]--;
      end
      if (!e_wait) begin
        foreach (m_lds[i]) begin
          if (m_lds[i].stage >= e_k && m_lds[i].stage + 1 <= D + LL)
            nq.push_back('{m_lds[i].stage + 1, m_lds[i].rd});
        end
        if (ld_issue_v_i && !e_hit && !(e_k > D)) nq.push_back('{D + 1, ld_rd_i});
        m_lds = nq;
      end
`ifdef RVGA_HAZARD_WATCHDOG_EN
      if (e_wait) begin
        if (m_wd < (1 << TW) - 1) m_wd++;
        if (m_wd == (1 << TW) - 1) m_to = 1;
      end else begin
        m_wd = 0;
      end
`endif
    end
    #1;
  endtask

  initial begin
    clr();
    m_wd = 0; m_to = 0;
    for (int p = 0; p < P; p++) m_cnt[p] = 0;
    @(posedge clk); #1;

    // Reset with everything raised: outputs stay 0.
    reset_i = 1'b1; br_v_i = '1; mem_need_v_i = '1; mem_req_v_i = '1;
    chk_model(); chk("rst_stall", stall_v_o, 0); chk("rst_flush", flush_v_o, 0); adv();
    chk_model(); adv();
    clr();
    chk_model();
    chk("post_rst_stall", stall_v_o, 0); chk("post_rst_wait", mem_wait_v_o, 0);
    chk("post_rst_full", mem_full_o, 0); chk("post_rst_bub", bubble_v_o, 0);
    adv();

    // dmem wait for 3 cycles, released by a same-cycle response.
    mem_req_v_i = 2'b10; chk_model(); adv(); clr();
    mem_need_v_i = 2'b10;
    repeat (3) begin
      chk_model(); chk("mw_wait", mem_wait_v_o, 1); chk("mw_stall", stall_v_o, 6'b111111); adv();
    end
    mem_resp_v_i = 2'b10; chk_model(); chk("mw_release", mem_wait_v_o, 0); adv();
    mem_resp_v_i = '0; chk_model(); chk("mw_cnt_zero", mem_wait_v_o, 0); adv(); clr();

    // Saturation then underflow on port 0.
    mem_req_v_i = 2'b01;
    repeat (3) begin chk_model(); adv(); end
    clr(); chk_model(); chk("sat_full", mem_full_o[0], 1); adv();
    mem_resp_v_i = 2'b01; chk_model(); adv(); chk_model(); chk("sat_dec", mem_full_o[0], 0); adv();
    chk_model(); adv(); clr();
    mem_need_v_i = 2'b01; chk_model(); chk("no_wrap", mem_wait_v_o, 0); adv(); clr();

    // Load-use with rd=5, two bubbles.
    ld_issue_v_i = 1'b1; ld_rd_i = 5'd5; chk_model(); adv(); clr();
    rs_v_i = 2'b01; rs1_i = 5'd5;
    repeat (2) begin
      chk_model(); chk("lu_bub", bubble_v_o, 1); chk("lu_stall", stall_v_o, 6'b000011); adv();
    end
    chk_model(); chk("lu_release", bubble_v_o, 0); adv(); clr();
    ld_issue_v_i = 1'b1; ld_rd_i = 5'd0; chk_model(); adv(); clr();
    rs_v_i = 2'b01; rs1_i = 5'd0; chk_model(); chk("x0_nohit", bubble_v_o, 0); adv(); clr();

    // Oldest-wins redirect.
    br_v_i = 6'b010100; chk_model(); chk("oldest", flush_v_o, 6'b001111); adv(); clr();

    // Redirect held across a memory wait.
    mem_req_v_i = 2'b10; chk_model(); adv(); clr();
    mem_need_v_i = 2'b10; br_v_i = 6'b010100;
    repeat (2) begin chk_model(); chk("held_flush", flush_v_o, 0); adv(); end
    mem_resp_v_i = 2'b10; chk_model(); chk("held_release", flush_v_o, 6'b001111); adv(); clr();

    // Flush of decode beats a load-use hit.
    ld_issue_v_i = 1'b1; ld_rd_i = 5'd7; chk_model(); adv(); clr();
    rs_v_i = 2'b01; rs1_i = 5'd7; br_v_i = 6'b001000;
    chk_model(); chk("col_bub", bubble_v_o, 0); chk("col_flush", flush_v_o, 6'b000111);
    chk("col_stall", stall_v_o, 0); adv();
    br_v_i = '0; chk_model(); chk("col_cleared", bubble_v_o, 0); adv(); clr();

    // Long wait: watchdog fires only when built in.
    mem_req_v_i = 2'b10; chk_model(); adv(); clr();
    mem_need_v_i = 2'b10;
    repeat (WD_N) begin chk_model(); chk("wd_wait", mem_wait_v_o, 1); adv(); end
    mem_resp_v_i = 2'b10; chk_model(); chk("wd_to", timeout_o, EXP_TO); adv(); clr();
    chk_model(); chk("wd_sticky", timeout_o, EXP_TO); adv();

    // Reset mid-operation: late responses are ignored.
    mem_req_v_i = 2'b01; repeat (2) begin chk_model(); adv(); end
    clr(); reset_i = 1'b1; chk_model(); adv(); clr();
    mem_resp_v_i = 2'b01; chk_model(); adv(); clr();
    mem_need_v_i = 2'b01; chk_model(); chk("rst_discard", mem_wait_v_o, 0); adv(); clr();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      reset_i      = ($urandom_range(0, 99) == 0);
      mem_req_v_i  = P'($urandom);
      mem_resp_v_i = P'($urandom);
      mem_need_v_i = ($urandom_range(0, 2) == 0) ? P'($urandom) : '0;
      br_v_i       = ($urandom_range(0, 5) == 0) ? S'($urandom) : '0;
      ld_issue_v_i = ($urandom_range(0, 2) == 0);
      ld_rd_i      = RW'($urandom_range(0, 7));
      rs_v_i       = 2'($urandom);
      rs1_i        = RW'($urandom_range(0, 7));
      rs2_i        = RW'($urandom_range(0, 7));
      chk_model(); adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
